// File: rtl/alu_op_sequencer.sv
// Decodes one 16-bit ALU instruction into ALU controls, sequences operand read, execute and writeback.
// Latency: done/rf_we 3 cycles after accept (err 2 cycles for illegal words); instr_ready only in IDLE, one instruction per 4 cycles.
module alu_op_sequencer #(
   parameter bit IMM_SEXT = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_valid,
   input  logic [15:0] instr,
   output logic        instr_ready,
   output logic [2:0]  rf_raddr1,
   output logic [2:0]  rf_raddr2,
   input  logic [7:0]  rf_rdata1,
   input  logic [7:0]  rf_rdata2,
   output logic        rf_we,
   output logic [2:0]  rf_waddr,
   output logic [7:0]  rf_wdata,
   output logic [7:0]  alu_a,
   output logic [7:0]  alu_b,
   output logic        is_shift,
   output logic [1:0]  scode,
   output logic [2:0]  acode,
   output logic        carry_in,
   input  logic [7:0]  alu_r,
   input  logic        alu_zero,
   input  logic        alu_cout,
   output logic        flag_c,
   output logic        flag_z,
   output logic        done,
   output logic        err
);

   typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

   state_t      state_q, state_d;
   logic [15:0] instr_q;
   logic [7:0]  alu_a_q, alu_b_q, rf_wdata_q;
   logic        is_shift_q;
   logic [1:0]  scode_q;
   logic [2:0]  acode_q, rf_waddr_q;
   logic        rf_we_q, done_q, err_q;
   logic        flag_c_q, flag_z_q, zero_q, cout_q;

   logic        op_s, op_i, illegal;
   logic [2:0]  op_code, op_rd, op_rs, op_rt;
   logic [4:0]  op_imm;
   logic [7:0]  imm_ext, b_raw, b_cond;

   assign op_s    = instr_q[15];
   assign op_i    = instr_q[14];
   assign op_code = instr_q[13:11];
   assign op_rd   = instr_q[10:8];
   assign op_rs   = instr_q[7:5];
   assign op_rt   = instr_q[4:2];
   assign op_imm  = instr_q[4:0];
   assign illegal = op_s ? op_code[2] : (op_code == 3'b111);

   // Shift amounts are clamped to 8 for shifts and reduced mod 8 for rotates.
   always_comb begin
      imm_ext = {3'b000, op_imm};
      if (IMM_SEXT && !op_s) begin
         imm_ext = {{3{op_imm[4]}}, op_imm};
      end
      b_raw  = op_i ? imm_ext : rf_rdata2;
      b_cond = b_raw;
      if (op_s) begin
         if (op_code[1]) begin
            b_cond = {5'b00000, b_raw[2:0]};
         end else if (b_raw > 8'd8) begin
            b_cond = 8'd8;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:   if (instr_valid) state_d = DECODE;
         DECODE: state_d = illegal ? WB : EXEC;
         EXEC:   state_d = WB;
         WB:     state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         instr_q    <= '0;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         is_shift_q <= 1'b0;
         scode_q    <= '0;
         acode_q    <= '0;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         zero_q     <= 1'b0;
         cout_q     <= 1'b0;
         flag_c_q   <= 1'b0;
         flag_z_q   <= 1'b0;
      end else begin
         rf_we_q <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (instr_valid) instr_q <= instr;
            end
            DECODE: begin
               if (illegal) begin
                  err_q <= 1'b1;
               end else begin
                  alu_a_q    <= rf_rdata1;
                  alu_b_q    <= b_cond;
                  is_shift_q <= op_s;
                  if (op_s) scode_q <= op_code[1:0];
                  else      acode_q <= op_code;
               end
            end
            EXEC: begin
               rf_wdata_q <= alu_r;
               zero_q     <= alu_zero;
               cout_q     <= alu_cout;
               rf_waddr_q <= op_rd;
               rf_we_q    <= (op_rd != 3'd0);
               done_q     <= 1'b1;
            end
            WB: begin
               // Only add/sub family owns the carry; logic ops and shifts leave it alone.
               if (!illegal) begin
                  flag_z_q <= zero_q;
                  if (!op_s && !op_code[2]) flag_c_q <= cout_q;
               end
            end
         endcase
      end
   end

   assign instr_ready = (state_q == IDLE) && !rst;
   assign rf_raddr1   = op_rs;
   assign rf_raddr2   = op_rt;
   assign rf_we       = rf_we_q;
   assign rf_waddr    = rf_waddr_q;
   assign rf_wdata    = rf_wdata_q;
   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign is_shift    = is_shift_q;
   assign scode       = scode_q;
   assign acode       = acode_q;
   assign carry_in    = flag_c_q;
   assign flag_c      = flag_c_q;
   assign flag_z      = flag_z_q;
   assign done        = done_q;
   assign err         = err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: bench-side ALU and register file, transaction-level
// reference model, per-cycle compare, directed scenarios then randomized instructions.
`timescale 1ns/1ps
module tb_alu_op_sequencer;
   localparam bit IMM_SEXT = 1'b0;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        instr_valid = 1'b0;
   logic [15:0] instr = '0;
   logic        instr_ready;
   logic [2:0]  rf_raddr1, rf_raddr2, rf_waddr;
   logic [7:0]  rf_rdata1, rf_rdata2, rf_wdata;
   logic        rf_we;
   logic [7:0]  alu_a, alu_b, alu_r;
   logic        is_shift, carry_in, alu_zero, alu_cout;
   logic [1:0]  scode;
   logic [2:0]  acode;
   logic        flag_c, flag_z, done, err;

   logic [7:0]  rf_mem [8];
   logic [7:0]  pl_img [8];
   logic        pl_vld = 1'b0;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   alu_op_sequencer #(.IMM_SEXT(IMM_SEXT)) dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
      .instr_ready(instr_ready), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
      .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .rf_we(rf_we),
      .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .alu_a(alu_a), .alu_b(alu_b),
      .is_shift(is_shift), .scode(scode), .acode(acode), .carry_in(carry_in),
      .alu_r(alu_r), .alu_zero(alu_zero), .alu_cout(alu_cout),
      .flag_c(flag_c), .flag_z(flag_z), .done(done), .err(err)
   );

   // Reference ALU: returns {zero, cout, r}.
   function automatic logic [9:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic sh, input logic [1:0] sc,
                                        input logic [2:0] ac, input logic cin);
      logic [8:0]  t;
      logic [15:0] w;
      t = '0;
      w = {a, a};
      if (sh) begin
         case (sc)
            2'd0: t[7:0] = a << b;
            2'd1: t[7:0] = a >> b;
            2'd2: begin w = w << b[2:0]; t[7:0] = w[15:8]; end
            default: begin w = w >> b[2:0]; t[7:0] = w[7:0]; end
         endcase
      end else begin
         case (ac)
            3'd0: t = {1'b0, a} + {1'b0, b};
            3'd1: t = {1'b0, a} + {1'b0, b} + {8'd0, cin};
            3'd2: t = {1'b0, a} - {1'b0, b};
            3'd3: t = {1'b0, a} - {1'b0, b} - {8'd0, cin};
            3'd4: t = {1'b0, a & b};
            3'd5: t = {1'b0, a | b};
            3'd6: t = {1'b0, a ^ b};
            default: t = '0;
         endcase
      end
      return {(t[7:0] == 8'd0), t[8], t[7:0]};
   endfunction

   logic [9:0] alu_res;
   assign alu_res   = alu_f(alu_a, alu_b, is_shift, scode, acode, carry_in);
   assign alu_r     = alu_res[7:0];
   assign alu_cout  = alu_res[8];
   assign alu_zero  = alu_res[9];
   assign rf_rdata1 = rf_mem[rf_raddr1];
   assign rf_rdata2 = rf_mem[rf_raddr2];

   always @(posedge clk) begin
      if (pl_vld) rf_mem <= pl_img;
      if (rf_we) rf_mem[rf_waddr] <= rf_wdata;
   end

   // Model: m_phase counts cycles since accept (0 = idle).
   int          m_phase = 0;
   logic        m_legal = 1'b0;
   logic [15:0] m_instr = '0;
   logic [7:0]  m_a = '0, m_b = '0, m_r = '0;
   logic        m_zero = 1'b0, m_cout = 1'b0, m_c = 1'b0, m_z = 1'b0;
   int          tcount = 0, acc_t = 0;

   // Observations collected by the compare step.
   int          done_cnt = 0, we_cnt = 0, err_cnt = 0, done_lat = 0;
   logic [7:0]  last_wdata = '0, exec_b = '0;
   logic [2:0]  last_waddr = '0;
   logic        exec_cin = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      logic [7:0] a, b;
      logic [9:0] res;
      logic       s;
      logic [2:0] op;
      tcount++;
      if (rst) begin
         m_phase = 0; m_c = 1'b0; m_z = 1'b0;
      end else if (m_phase == 0) begin
         if (instr_valid) begin
            m_instr = instr; acc_t = tcount; m_phase = 1;
            s  = instr[15];
            op = instr[13:11];
            m_legal = s ? (op < 3'd4) : (op != 3'd7);
            a = rf_mem[instr[7:5]];
            if (instr[14]) b = (IMM_SEXT && !s) ? {{3{instr[4]}}, instr[4:0]} : {3'b000, instr[4:0]};
            else           b = rf_mem[instr[4:2]];
            if (s) b = op[1] ? (b % 8'd8) : ((b > 8'd8) ? 8'd8 : b);
            res = alu_f(a, b, s, op[1:0], op, m_c);
            m_a = a; m_b = b; m_r = res[7:0]; m_cout = res[8]; m_zero = res[9];
         end
      end else if (m_phase == (m_legal ? 3 : 2)) begin
         if (m_legal) begin
            m_z = m_zero;
            if (!m_instr[15] && m_instr[13:11] < 3'd4) m_c = m_cout;
         end
         m_phase = 0;
      end else begin
         m_phase++;
      end
   endtask

   task automatic compare();
      logic wb, ex;
      wb = m_legal && (m_phase == 3);
      ex = m_legal && (m_phase == 2);
      chk("instr_ready", instr_ready, (m_phase == 0) && !rst);
      chk("done", done, wb);
      chk("err", err, !m_legal && (m_phase == 2));
      chk("rf_we", rf_we, wb && (m_instr[10:8] != 3'd0));
      chk("flag_c", flag_c, m_c);
      chk("flag_z", flag_z, m_z);
      chk("carry_in", carry_in, m_c);
      if (wb) begin
         chk("rf_wdata", rf_wdata, m_r);
         if (m_instr[10:8] != 3'd0) chk("rf_waddr", rf_waddr, m_instr[10:8]);
      end
      if (ex) begin
         chk("alu_a", alu_a, m_a);
         chk("alu_b", alu_b, m_b);
         chk("is_shift", is_shift, m_instr[15]);
         if (m_instr[15]) chk("scode", scode, m_instr[12:11]);
         else             chk("acode", acode, m_instr[13:11]);
         exec_cin = carry_in;
         exec_b   = alu_b;
      end
      if (done) begin
         done_cnt++; done_lat = tcount - acc_t + 1;
         last_wdata = rf_wdata; last_waddr = rf_waddr;
      end
      if (rf_we) we_cnt++;
      if (err) err_cnt++;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare();
   endtask

   task automatic set_rf(input int i1, input logic [7:0] v1, input int i2, input logic [7:0] v2);
      pl_img = rf_mem;
      pl_img[i1] = v1;
      pl_img[i2] = v2;
      pl_img[0] = 8'd0;
      pl_vld = 1'b1;
      tick();
      pl_vld = 1'b0;
   endtask

   function automatic logic [15:0] enc(input logic s, input logic i, input logic [2:0] op,
                                       input logic [2:0] rd, input logic [2:0] rs, input logic [4:0] lo);
      return {s, i, op, rd, rs, lo};
   endfunction

   task automatic issue(input logic [15:0] w, input bit hold);
      bit ok;
      ok = 1'b0;
      instr_valid = 1'b1;
      instr = w;
      for (int k = 0; k < 12 && !ok; k++) begin
         tick();
         if (m_phase == 1) ok = 1'b1;
      end
      if (!ok) chk("accept_timeout", 0, 1);
      if (hold) begin
         instr = 16'($urandom);
         tick();
      end
      instr_valid = 1'b0;
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 10 && m_phase != 0; k++) tick();
      if (m_phase != 0) chk("idle_timeout", 0, 1);
   endtask

   task automatic run(input logic [15:0] w);
      issue(w, 1'b0);
      wait_idle();
   endtask

   initial begin
      int d0, w0, e0, dly;
      logic [15:0] w;
      pl_img = '{default: 8'd0};
      pl_vld = 1'b1;
      tick();
      pl_vld = 1'b0;
      tick();
      rst = 1'b0;
      #1;
      chk("rst_alu_a", alu_a, 0);
      chk("rst_alu_b", alu_b, 0);
      chk("rst_ctrl", {is_shift, scode, acode}, 0);
      chk("rst_rf", {rf_we, rf_waddr, rf_wdata}, 0);
      chk("rst_pulses", {done, err}, 0);
      chk("rst_flags", {flag_c, flag_z}, 0);
      chk("rst_ready", instr_ready, 1);

      // ADD r1 = r2 + r3
      set_rf(2, 8'h7F, 3, 8'h01);
      run(enc(0, 0, 3'd0, 3'd1, 3'd2, {3'd3, 2'b00}));
      chk("add_latency", done_lat, 3);
      chk("add_waddr", last_waddr, 1);
      chk("add_wdata", last_wdata, 8'h80);
      chk("add_flags", {flag_c, flag_z}, 2'b00);

      set_rf(4, 8'hFF, 5, 8'h01);
      run(enc(0, 0, 3'd0, 3'd6, 3'd4, {3'd5, 2'b00}));
      chk("addff_flags", {flag_c, flag_z}, 2'b11);
      set_rf(4, 8'h10, 5, 8'h20);
      run(enc(0, 0, 3'd1, 3'd6, 3'd4, {3'd5, 2'b00}));
      chk("addc_cin", exec_cin, 1);
      chk("addc_wdata", last_wdata, 8'h31);
      chk("addc_flags", {flag_c, flag_z}, 2'b00);

      set_rf(4, 8'hFF, 5, 8'h01);
      run(enc(0, 0, 3'd0, 3'd6, 3'd4, {3'd5, 2'b00}));
      set_rf(4, 8'hF0, 5, 8'h0F);
      run(enc(0, 0, 3'd4, 3'd6, 3'd4, {3'd5, 2'b00}));
      chk("and_wdata", last_wdata, 8'h00);
      chk("and_flags", {flag_c, flag_z}, 2'b11);

      set_rf(4, 8'h81, 5, 8'h20);
      run(enc(1, 1, 3'd2, 3'd6, 3'd4, 5'd9));
      chk("rol9_alu_b", exec_b, 8'h01);
      chk("rol9_wdata", last_wdata, 8'h03);
      run(enc(1, 0, 3'd0, 3'd6, 3'd4, {3'd5, 2'b00}));
      chk("shl_alu_b", exec_b, 8'h08);

      d0 = done_cnt; w0 = we_cnt; e0 = err_cnt;
      run(enc(0, 0, 3'd7, 3'd1, 3'd2, 5'd0));
      run(enc(1, 0, 3'd4, 3'd1, 3'd2, 5'd0));
      chk("illegal_err", err_cnt - e0, 2);
      chk("illegal_done", done_cnt - d0, 0);
      chk("illegal_we", we_cnt - w0, 0);
      chk("illegal_flags", {flag_c, flag_z}, 2'b11);

      set_rf(4, 8'h55, 5, 8'h55);
      d0 = done_cnt; w0 = we_cnt;
      run(enc(0, 0, 3'd2, 3'd0, 3'd4, {3'd4, 2'b00}));
      chk("r0_done", done_cnt - d0, 1);
      chk("r0_we", we_cnt - w0, 0);
      chk("r0_flags", {flag_c, flag_z}, 2'b01);

      // Reset while an ADD sits in EXEC.
      d0 = done_cnt; w0 = we_cnt;
      issue(enc(0, 0, 3'd0, 3'd1, 3'd2, {3'd3, 2'b00}), 1'b0);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("abort_ready", instr_ready, 1);
      chk("abort_alu_a", alu_a, 0);
      chk("abort_flags", {flag_c, flag_z}, 2'b00);
      tick();
      tick();
      chk("abort_done", done_cnt - d0, 0);
      chk("abort_we", we_cnt - w0, 0);
      run(enc(0, 0, 3'd0, 3'd1, 3'd2, {3'd3, 2'b00}));
      chk("post_abort_wdata", last_wdata, 8'h80);
      chk("post_abort_done", done_cnt - d0, 1);

      // Randomized instructions with occasional register refresh, idle gaps and aborts.
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 1) == 0) begin
            set_rf($urandom_range(1, 7),
                   ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 10)) : 8'($urandom),
                   $urandom_range(1, 7), 8'($urandom));
         end
         for (int g = $urandom_range(0, 2); g > 0; g--) tick();
         w = 16'($urandom);
         issue(w, $urandom_range(0, 3) == 0);
         if ($urandom_range(0, 24) == 0) begin
            dly = $urandom_range(0, 2);
            for (int k = 0; k < dly; k++) tick();
            rst = 1'b1;
            tick();
            rst = 1'b0;
         end
         wait_idle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
